ika87ad_extbus_arbiter: RTL and testbench
=========================================

// Module: ika87ad_extbus_arbiter
//
// PURPOSE
// Shares the IKA87AD external memory bus between two masters: port 0 (CPU core)
// and port 1 (DMA/loader). Grants one transaction at a time and sequences the
// multiplexed bus cycle: ALE, RD_n/WR_n, programmable wait states and read-data
// capture. Sits between the CPU/DMA request interfaces and the AD[7:0]/A[15:8] pins.
//
// PARAMETERS
// WAIT_STATES   1  extra PCEN ticks inserted in TW (0..7)
// RR_ENABLE     1  1 = round-robin on simultaneous requests; 0 = port 0 always wins
//
// PORTS
// i_EMUCLK       in   1   system clock
// i_RESET_n      in   1   asynchronous active-low reset
// i_MCUCLK_PCEN  in   1   bus-timing clock enable; every state advance happens only on this tick
// i_REQ0/i_REQ1  in   1   level request; held until the matching ack
// i_WE0/i_WE1    in   1   1 = write, 0 = read; stable while REQ is high
// i_ADDR0/1      in   16  transaction address
// i_WDATA0/1     in   8   write data
// o_ACK0/o_ACK1  out  1   one-EMUCLK pulse at transaction end
// o_RDATA        out  8   read data; valid with ACK, held until next read capture
// o_ALE          out  1   address latch enable
// o_RD_n/o_WR_n  out  1   bus strobes, active low
// o_A_HI         out  8   address [15:8]
// o_AD_O         out  8   multiplexed address[7:0]/write data
// o_AD_OE        out  1   1 = drive AD pins
// i_AD_I         in   8   AD pin input
// o_GNT          out  1   current/last owner (0 = port 0)
//
// BEHAVIOUR
// - Reset (asynchronous): state=IDLE, ALE=0, RD_n=WR_n=1, AD_OE=0, ACK0=ACK1=0,
//   A_HI=AD_O=RDATA=0, GNT=0, round-robin pointer favours port 0.
// - FSM (each state lasts exactly one PCEN tick; TW lasts WAIT_STATES ticks):
//   IDLE -> T1 on a PCEN tick with any REQ high; latch owner, addr, we, wdata.
//   T1: ALE=1, AD_OE=1, AD_O=addr[7:0], A_HI=addr[15:8].
//   T2: ALE=0, address held. Read: AD_OE=0, RD_n=0. Write: AD_O=wdata, WR_n=0.
//   TW: strobes held and a down-counter runs; skipped when WAIT_STATES=0.
//   T3: strobe held. On the closing PCEN tick: read captures i_AD_I into RDATA,
//       strobe deasserts, AD_OE=0, owner's ACK pulses for one EMUCLK, -> IDLE.
// - Total cycle = 3 + WAIT_STATES PCEN ticks from IDLE exit to ACK.
// - Arbitration happens only in IDLE. With both REQs high and RR_ENABLE=1, the
//   port not served last wins; the pointer updates at grant. A request that drops
//   early is ignored once latched; the transaction completes anyway.
// - A_HI holds the last address in IDLE. No back-to-back overlap: the next T1
//   starts no earlier than the PCEN tick after ACK.
// - Without PCEN ticks the FSM freezes with all outputs held.
// - Reset asserted mid-cycle: strobes release immediately; no ACK is issued.
//
// TESTING
// 1. REQ0 read 0x0123, WAIT_STATES=1, i_AD_I=0xA5 -> ALE 1 tick with AD_O=0x23,
//    A_HI=0x01; RD_n low 3 ticks; ACK0 at tick 4; RDATA=0xA5.
// 2. REQ1 write 0x01FF data 0x5A -> WR_n low, AD_O=0x5A, AD_OE=1 during
//    T2..T3; ACK1 only; RD_n stays 1.
// 3. REQ0 and REQ1 asserted on the same tick, each held for 2 transactions ->
//    grant order 0,1,0,1 with RR_ENABLE=1, and 0,0 then 1,1 with RR_ENABLE=0.
// 4. WAIT_STATES=0 and =7 -> ACK after 3 and 10 PCEN ticks.
// 5. Reset pulled low during T2 of a write -> WR_n=1, AD_OE=0 asynchronously;
//    no ACK; the next request starts cleanly at T1.
// 6. PCEN gated off for 5 ticks in TW -> outputs frozen; cycle resumes and
//    completes correctly.

Source files
------------

// File: rtl/ika87ad_extbus_arbiter.sv
// External bus arbiter for the IKA87AD: grants one of two masters and runs the
// multiplexed ALE / strobe / wait-state / capture sequence on PCEN ticks.
module ika87ad_extbus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int RR_ENABLE   = 1
) (
    input  logic        i_EMUCLK,
    input  logic        i_RESET_n,
    input  logic        i_MCUCLK_PCEN,
    input  logic        i_REQ0,
    input  logic        i_REQ1,
    input  logic        i_WE0,
    input  logic        i_WE1,
    input  logic [15:0] i_ADDR0,
    input  logic [15:0] i_ADDR1,
    input  logic [7:0]  i_WDATA0,
    input  logic [7:0]  i_WDATA1,
    output logic        o_ACK0,
    output logic        o_ACK1,
    output logic [7:0]  o_RDATA,
    output logic        o_ALE,
    output logic        o_RD_n,
    output logic        o_WR_n,
    output logic [7:0]  o_A_HI,
    output logic [7:0]  o_AD_O,
    output logic        o_AD_OE,
    input  logic [7:0]  i_AD_I,
    output logic        o_GNT
);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t      state;
    logic [2:0]  wait_cnt;
    logic        last_port;
    logic        we_q;
    logic [7:0]  wdata_q;

    logic        req0, req1, pick;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

    // A port whose ACK is on the wire this cycle has not yet had a chance to drop
    // its REQ, so it is masked to avoid a phantom second transaction.
    always_comb begin
        req0 = i_REQ0 & ~o_ACK0;
        req1 = i_REQ1 & ~o_ACK1;
        pick = 1'b0;
        if (req0 && req1)
            pick = (RR_ENABLE != 0) ? ~last_port : 1'b0;
        else if (req1)
            pick = 1'b1;
        sel_we    = pick ? i_WE1    : i_WE0;
        sel_addr  = pick ? i_ADDR1  : i_ADDR0;
        sel_wdata = pick ? i_WDATA1 : i_WDATA0;
    end

    always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            last_port <= 1'b1;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
            o_ACK0    <= 1'b0;
            o_ACK1    <= 1'b0;
            o_RDATA   <= 8'h00;
            o_ALE     <= 1'b0;
            o_RD_n    <= 1'b1;
            o_WR_n    <= 1'b1;
            o_A_HI    <= 8'h00;
            o_AD_O    <= 8'h00;
            o_AD_OE   <= 1'b0;
            o_GNT     <= 1'b0;
        end else begin
            o_ACK0 <= 1'b0;
            o_ACK1 <= 1'b0;
            if (i_MCUCLK_PCEN) begin
                case (state)
                    IDLE: begin
                        if (req0 || req1) begin
                            last_port <= pick;
                            o_GNT     <= pick;
                            we_q      <= sel_we;
                            wdata_q   <= sel_wdata;
                            o_A_HI    <= sel_addr[15:8];
                            o_AD_O    <= sel_addr[7:0];
                            o_ALE     <= 1'b1;
                            o_AD_OE   <= 1'b1;
                            state     <= T1;
                        end
                    end
                    T1: begin
                        o_ALE <= 1'b0;
                        if (we_q) begin
                            o_AD_O <= wdata_q;
                            o_WR_n <= 1'b0;
                        end else begin
                            o_AD_OE <= 1'b0;
                            o_RD_n  <= 1'b0;
                        end
                        state <= T2;
                    end
                    T2: begin
                        if (WAIT_STATES == 0) begin
                            state <= T3;
                        end else begin
                            wait_cnt <= WS_M1;
                            state    <= TW;
                        end
                    end
                    TW: begin
                        if (wait_cnt == 3'd0)
                            state <= T3;
                        else
                            wait_cnt <= wait_cnt - 3'd1;
                    end
                    T3: begin
                        if (!we_q)
                            o_RDATA <= i_AD_I;
                        o_RD_n  <= 1'b1;
                        o_WR_n  <= 1'b1;
                        o_AD_OE <= 1'b0;
                        if (o_GNT)
                            o_ACK1 <= 1'b1;
                        else
                            o_ACK0 <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ika87ad_extbus_arbiter.sv
// Bench for ika87ad_extbus_arbiter: three instances (WS=1/RR, WS=0/fixed, WS=7/RR)
// checked tick by tick against a phase-number model of the bus cycle.
module tb_ika87ad_extbus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic pcen;

    logic        req0 [3], req1 [3], we0 [3], we1 [3];
    logic [15:0] addr0 [3], addr1 [3];
    logic [7:0]  wdata0 [3], wdata1 [3], ad_i [3];
    logic        ack0 [3], ack1 [3], ale [3], rd_n [3], wr_n [3], ad_oe [3], gnt [3];
    logic [7:0]  rdata [3], a_hi [3], ad_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int         last_m [3];
    logic [7:0] rdata_m [3];
    int         cnt0 [3], cnt1 [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ika87ad_extbus_arbiter #(
            .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 7)),
            .RR_ENABLE  (g == 1 ? 0 : 1)
        ) u_dut (
            .i_EMUCLK     (clk),
            .i_RESET_n    (rst_n),
            .i_MCUCLK_PCEN(pcen),
            .i_REQ0       (req0[g]),
            .i_REQ1       (req1[g]),
            .i_WE0        (we0[g]),
            .i_WE1        (we1[g]),
            .i_ADDR0      (addr0[g]),
            .i_ADDR1      (addr1[g]),
            .i_WDATA0     (wdata0[g]),
            .i_WDATA1     (wdata1[g]),
            .o_ACK0       (ack0[g]),
            .o_ACK1       (ack1[g]),
            .o_RDATA      (rdata[g]),
            .o_ALE        (ale[g]),
            .o_RD_n       (rd_n[g]),
            .o_WR_n       (wr_n[g]),
            .o_A_HI       (a_hi[g]),
            .o_AD_O       (ad_o[g]),
            .o_AD_OE      (ad_oe[g]),
            .i_AD_I       (ad_i[g]),
            .o_GNT        (gnt[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
    endfunction

    function automatic int rr_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    task automatic chk_b(input string tag, input int k, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // one PCEN pulse; returns at the falling edge right after the enabled rising edge
    task automatic pcen_tick();
        @(negedge clk) pcen = 1'b1;
        @(negedge clk) pcen = 1'b0;
    endtask

    task automatic post(input int k, input int port, input logic we, input logic [15:0] a,
                        input logic [7:0] d, input int n);
        if (port == 0) begin
            we0[k] = we; addr0[k] = a; wdata0[k] = d; cnt0[k] = n; req0[k] = 1'b1;
        end else begin
            we1[k] = we; addr1[k] = a; wdata1[k] = d; cnt1[k] = n; req1[k] = 1'b1;
        end
    endtask

    // expected pins p ticks after leaving IDLE (p=0 is T1, strobes from p=1 on)
    task automatic phase_chk(input int k, input int p, input logic owner, input logic we,
                             input logic [15:0] addr, input logic [7:0] wd);
        chk_b("ale", k, ale[k], p == 0);
        chk_b("rd_n", k, rd_n[k], !(!we && p >= 1));
        chk_b("wr_n", k, wr_n[k], !(we && p >= 1));
        chk_b("ad_oe", k, ad_oe[k], (p == 0) || (we && p >= 1));
        if (p == 0 || we)
            chk_v("ad_o", k, {8'h00, ad_o[k]}, {8'h00, (p == 0) ? addr[7:0] : wd});
        chk_v("a_hi", k, {8'h00, a_hi[k]}, {8'h00, addr[15:8]});
        chk_b("gnt", k, gnt[k], owner);
        chk_b("ack0", k, ack0[k], 1'b0);
        chk_b("ack1", k, ack1[k], 1'b0);
    endtask

    // run one full transaction on instance k; the owner is predicted from the arbitration rule
    task automatic serve(input int k, input logic [7:0] adv, input int freeze_at);
        logic        owner, we;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          ws;
        ws = ws_of(k);
        if (req0[k] && req1[k])
            owner = (rr_of(k) != 0) ? (last_m[k] == 0) : 1'b0;
        else
            owner = req1[k];
        last_m[k] = owner ? 1 : 0;
        we   = owner ? we1[k]    : we0[k];
        addr = owner ? addr1[k]  : addr0[k];
        wd   = owner ? wdata1[k] : wdata0[k];
        ad_i[k] = adv;
        for (int p = 0; p <= 3 + ws; p++) begin
            pcen_tick();
            if (p < 3 + ws) begin
                phase_chk(k, p, owner, we, addr, wd);
                if (p == freeze_at) begin
                    repeat (15) @(negedge clk);
                    phase_chk(k, p, owner, we, addr, wd);
                end
            end
        end
        if (!we) rdata_m[k] = adv;
        chk_b("ack0_end", k, ack0[k], !owner);
        chk_b("ack1_end", k, ack1[k], owner);
        chk_b("rd_n_end", k, rd_n[k], 1'b1);
        chk_b("wr_n_end", k, wr_n[k], 1'b1);
        chk_b("ad_oe_end", k, ad_oe[k], 1'b0);
        chk_b("ale_end", k, ale[k], 1'b0);
        chk_v("rdata", k, {8'h00, rdata[k]}, {8'h00, rdata_m[k]});
        if (owner) begin
            cnt1[k]--;
            if (cnt1[k] <= 0) req1[k] = 1'b0;
        end else begin
            cnt0[k]--;
            if (cnt0[k] <= 0) req0[k] = 1'b0;
        end
        @(negedge clk);
        chk_b("ack0_pulse", k, ack0[k], 1'b0);
        chk_b("ack1_pulse", k, ack1[k], 1'b0);
        chk_v("a_hi_idle", k, {8'h00, a_hi[k]}, {8'h00, addr[15:8]});
        chk_b("gnt_idle", k, gnt[k], owner);
    endtask

    task automatic reset_chk(input int k);
        chk_b("rst_ale", k, ale[k], 1'b0);
        chk_b("rst_rd_n", k, rd_n[k], 1'b1);
        chk_b("rst_wr_n", k, wr_n[k], 1'b1);
        chk_b("rst_ad_oe", k, ad_oe[k], 1'b0);
        chk_b("rst_ack0", k, ack0[k], 1'b0);
        chk_b("rst_ack1", k, ack1[k], 1'b0);
        chk_b("rst_gnt", k, gnt[k], 1'b0);
        chk_v("rst_a_hi", k, {8'h00, a_hi[k]}, 16'h0000);
        chk_v("rst_ad_o", k, {8'h00, ad_o[k]}, 16'h0000);
        chk_v("rst_rdata", k, {8'h00, rdata[k]}, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        pcen  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req0[k] = 1'b0; req1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
            addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0; ad_i[k] = '0;
            last_m[k] = 1; rdata_m[k] = '0; cnt0[k] = 0; cnt1[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) reset_chk(k);
        rst_n = 1'b1;
        @(negedge clk);

        // directed read, then write
        post(0, 0, 1'b0, 16'h0123, 8'h00, 1);
        serve(0, 8'hA5, -1);
        post(0, 1, 1'b1, 16'h01FF, 8'h5A, 1);
        serve(0, 8'h3C, -1);

        // simultaneous requests, two transactions each
        for (int k = 0; k < 2; k++) begin
            post(k, 0, 1'b0, 16'h1000 + 16'(k), 8'h11, 2);
            post(k, 1, 1'b1, 16'h2000 + 16'(k), 8'h22, 2);
            for (int j = 0; j < 4; j++) serve(k, 8'(8'h40 + j), -1);
        end

        // wait-state extremes, including a PCEN stall inside TW
        post(1, 0, 1'b0, 16'hBEEF, 8'h00, 1);
        serve(1, 8'h77, -1);
        post(2, 1, 1'b0, 16'hCAFE, 8'h00, 1);
        serve(2, 8'h99, 4);
        post(2, 0, 1'b1, 16'h8001, 8'hE1, 1);
        serve(2, 8'h12, -1);

        // reset in T2 of a write
        post(0, 1, 1'b1, 16'h4466, 8'h77, 1);
        pcen_tick();
        pcen_tick();
        chk_b("pre_rst_wr_n", 0, wr_n[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk_b("async_wr_n", 0, wr_n[0], 1'b1);
        chk_b("async_ad_oe", 0, ad_oe[0], 1'b0);
        req1[0] = 1'b0; cnt1[0] = 0;
        @(negedge clk);
        chk_b("rst_no_ack1", 0, ack1[0], 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            last_m[k] = 1; rdata_m[k] = '0;
        end
        @(negedge clk);
        reset_chk(0);
        post(0, 0, 1'b0, 16'h5A5A, 8'h00, 1);
        serve(0, 8'hC3, -1);

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            int  k;
            bit  r0, r1;
            k  = int'($urandom_range(0, 2));
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            if (r0) post(k, 0, 1'($urandom), 16'($urandom), 8'($urandom), 1);
            if (r1) post(k, 1, 1'($urandom), 16'($urandom), 8'($urandom), 1);
            for (int j = 0; j < 4 && (req0[k] || req1[k]); j++)
                serve(k, 8'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
